// File: rtl/dm_stream_loader.sv
// ---------------------------------------------------------------------------
// dm_stream_loader
//
// Loads a byte stream into a dual-port data memory as 32-bit words. Bytes are
// packed little-endian into words, words are paired into a two-slot buffer,
// and each pair (or a lone final word) is written in a single cycle using
// both memory ports at consecutive addresses.
//
// Ports
//   clk, rst_n           clock, synchronous active-low reset
//   start                one-cycle load request (honoured only when idle)
//   abort                abandon the current load at once
//   base_addr, word_cnt  first word address / number of words, latched on start
//   byte_in, byte_vld    incoming stream byte and its valid flag
//   byte_rdy             byte_in is accepted this cycle
//   addr0/1, we0/1       memory port addresses and write enables
//   wrt_data0/1          memory port write data
//   re0/1                memory read enables (never used, tied low)
//   busy                 a load is in progress
//   done                 one-cycle pulse when a load completes normally
// ---------------------------------------------------------------------------
module dm_stream_loader #(
  parameter int ADDR_W = 13,
  parameter int CNT_W  = 14
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  word_cnt,
  input  logic [7:0]        byte_in,
  input  logic              byte_vld,
  output logic              byte_rdy,
  output logic [ADDR_W-1:0] addr0,
  output logic [ADDR_W-1:0] addr1,
  output logic              we0,
  output logic              we1,
  output logic              re0,
  output logic              re1,
  output logic [31:0]       wrt_data0,
  output logic [31:0]       wrt_data1,
  output logic              busy,
  output logic              done
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FILL  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]        state;
  logic [ADDR_W-1:0] cur_addr;
  logic [CNT_W-1:0]  rem_cnt;
  logic [1:0]        byte_idx;
  logic [23:0]       word_acc;    // bytes 0..2 of the word being assembled
  logic [31:0]       slot0;
  logic [31:0]       slot1;
  logic              slot_sel;    // next completed word goes to slot1
  logic              slot1_full;

  logic              xfer;
  logic              wr_cycle;
  logic [31:0]       word_full;
  logic [CNT_W-1:0]  cnt_step;
  logic [ADDR_W-1:0] addr_step;

  assign xfer      = byte_vld && byte_rdy;
  // The 4th byte completes the word directly, so it never has to sit in
  // word_acc; this keeps the write one cycle after the last transfer.
  assign word_full = {byte_in, word_acc};
  assign cnt_step  = slot1_full ? CNT_W'(2) : CNT_W'(1);
  assign addr_step = slot1_full ? ADDR_W'(2) : ADDR_W'(1);

  // ---- control and pack state ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      cur_addr   <= '0;
      rem_cnt    <= '0;
      byte_idx   <= '0;
      word_acc   <= '0;
      slot0      <= '0;
      slot1      <= '0;
      slot_sel   <= 1'b0;
      slot1_full <= 1'b0;
    end else if (abort && (state != S_IDLE)) begin
      // Abort drops everything gathered so far; the next start reloads.
      state      <= S_IDLE;
      byte_idx   <= '0;
      word_acc   <= '0;
      slot0      <= '0;
      slot1      <= '0;
      slot_sel   <= 1'b0;
      slot1_full <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            cur_addr   <= base_addr;
            rem_cnt    <= word_cnt;
            byte_idx   <= '0;
            word_acc   <= '0;
            slot_sel   <= 1'b0;
            slot1_full <= 1'b0;
            state      <= (word_cnt == '0) ? S_DONE : S_FILL;
          end
        end
        S_FILL: begin
          if (xfer) begin
            byte_idx <= byte_idx + 2'd1;
            if (byte_idx == 2'd3) begin
              word_acc <= '0;
              if (!slot_sel) begin
                slot0 <= word_full;
                // A lone last word is flushed without waiting for a partner.
                if (rem_cnt == CNT_W'(1)) begin
                  state <= S_WRITE;
                end else begin
                  slot_sel <= 1'b1;
                end
              end else begin
                slot1      <= word_full;
                slot1_full <= 1'b1;
                state      <= S_WRITE;
              end
            end else begin
              case (byte_idx)
                2'd0:    word_acc[7:0]   <= byte_in;
                2'd1:    word_acc[15:8]  <= byte_in;
                default: word_acc[23:16] <= byte_in;
              endcase
            end
          end
        end
        S_WRITE: begin
          cur_addr   <= cur_addr + addr_step;
          rem_cnt    <= rem_cnt - cnt_step;
          slot_sel   <= 1'b0;
          slot1_full <= 1'b0;
          state      <= (rem_cnt == cnt_step) ? S_DONE : S_FILL;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // ---- memory and handshake outputs ----
  // Everything is forced quiet while rst_n is low, and abort suppresses the
  // write, ready and done of the cycle in which it is raised.
  always_comb begin
    wr_cycle  = rst_n && !abort && (state == S_WRITE);
    byte_rdy  = rst_n && !abort && (state == S_FILL);
    we0       = wr_cycle;
    we1       = wr_cycle && slot1_full;
    addr0     = we0 ? cur_addr : '0;
    addr1     = we1 ? (cur_addr + ADDR_W'(1)) : '0;
    wrt_data0 = we0 ? slot0 : '0;
    wrt_data1 = we1 ? slot1 : '0;
    re0       = 1'b0;
    re1       = 1'b0;
    busy      = rst_n && (state != S_IDLE);
    done      = rst_n && !abort && (state == S_DONE);
  end

endmodule

// File: tb/tb_dm_stream_loader.sv
module tb_dm_stream_loader;
  localparam int ADDR_W = 13;
  localparam int CNT_W  = 14;

  logic              clk = 1'b0;
  logic              rst_n, start, abort, byte_vld;
  logic [ADDR_W-1:0] base_addr;
  logic [CNT_W-1:0]  word_cnt;
  logic [7:0]        byte_in;
  logic              byte_rdy, we0, we1, re0, re1, busy, done;
  logic [ADDR_W-1:0] addr0, addr1;
  logic [31:0]       wrt_data0, wrt_data1;

  always #5 clk = ~clk;

  dm_stream_loader #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .base_addr(base_addr), .word_cnt(word_cnt),
    .byte_in(byte_in), .byte_vld(byte_vld), .byte_rdy(byte_rdy),
    .addr0(addr0), .addr1(addr1), .we0(we0), .we1(we1), .re0(re0), .re1(re1),
    .wrt_data0(wrt_data0), .wrt_data1(wrt_data1), .busy(busy), .done(done)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // A load is described by its base, its word count, the bytes accepted so
  // far and the number of words already written. A write is due once a full
  // pair (or the final word) of accepted bytes exists beyond what was written.
  typedef struct {
    logic [ADDR_W-1:0] a0;
    logic [31:0]       d0;
    logic              w1;
    logic [ADDR_W-1:0] a1;
    logic [31:0]       d1;
  } wr_t;

  wr_t               wlog[$];
  logic [7:0]        m_bytes[$];
  bit                m_busy, m_wr_due, m_done_due;
  int                m_cnt, m_written, nw, words;
  logic [ADDR_W-1:0] m_base;
  int                cyc = 0, start_cyc = 0, last_lat = -1, n_done = 0;
  logic              live, e_we0, e_we1, e_rdy, e_done, e_busy;
  logic [ADDR_W-1:0] e_a0, e_a1;
  logic [31:0]       e_d0, e_d1;
  wr_t               w;

  function automatic logic [31:0] word_at(int i);
    return {m_bytes[4*i+3], m_bytes[4*i+2], m_bytes[4*i+1], m_bytes[4*i]};
  endfunction

  always @(negedge clk) begin
    cyc++;
    live   = rst_n;
    nw     = ((m_cnt - m_written) >= 2) ? 2 : 1;
    e_busy = live && m_busy;
    e_done = live && m_done_due && !abort;
    e_we0  = live && m_wr_due && !abort;
    e_we1  = e_we0 && (nw == 2);
    e_rdy  = live && m_busy && !m_wr_due && !m_done_due && !abort;
    e_a0   = e_we0 ? ADDR_W'(m_base + ADDR_W'(m_written)) : '0;
    e_d0   = e_we0 ? word_at(m_written) : '0;
    e_a1   = e_we1 ? ADDR_W'(m_base + ADDR_W'(m_written + 1)) : '0;
    e_d1   = e_we1 ? word_at(m_written + 1) : '0;

    chk("busy", busy, e_busy);
    chk("done", done, e_done);
    chk("byte_rdy", byte_rdy, e_rdy);
    chk("we0", we0, e_we0);
    chk("we1", we1, e_we1);
    chk("re0", re0, 1'b0);
    chk("re1", re1, 1'b0);
    chk("addr0", addr0, e_a0);
    chk("addr1", addr1, e_a1);
    chk("wrt_data0", wrt_data0, e_d0);
    chk("wrt_data1", wrt_data1, e_d1);

    if (we0 === 1'b1) begin
      w.a0 = addr0; w.d0 = wrt_data0; w.w1 = we1; w.a1 = addr1; w.d1 = wrt_data1;
      wlog.push_back(w);
    end
    if (done === 1'b1) begin
      n_done++;
      last_lat = cyc - start_cyc;
    end

    // advance the model across the coming edge
    if (!rst_n) begin
      m_busy = 0; m_wr_due = 0; m_done_due = 0;
    end else if (m_busy && abort) begin
      m_busy = 0; m_wr_due = 0; m_done_due = 0;
    end else if (!m_busy) begin
      if (start) begin
        m_base = base_addr; m_cnt = int'(word_cnt); m_written = 0;
        m_bytes.delete(); wlog.delete();
        m_busy = 1; m_wr_due = 0; m_done_due = (word_cnt == '0);
        start_cyc = cyc;
      end
    end else if (m_done_due) begin
      m_busy = 0; m_done_due = 0;
    end else if (m_wr_due) begin
      m_written += nw;
      m_wr_due = 0;
      if (m_written == m_cnt) m_done_due = 1;
    end else if (byte_vld && e_rdy) begin
      m_bytes.push_back(byte_in);
      if (m_bytes.size() % 4 == 0) begin
        words = m_bytes.size() / 4;
        if ((words - m_written == 2) || (words == m_cnt)) m_wr_due = 1;
      end
    end
  end

  // ---------------- stimulus ----------------
  bit gap_mode = 0, rand_bytes = 0;
  int bidx = 0;

  function automatic logic [7:0] gen_byte(int i);
    return rand_bytes ? 8'($urandom) : 8'(i + 1);
  endfunction

  task automatic tick();
    bit xf;
    @(negedge clk);
    xf = byte_vld && byte_rdy;
    @(posedge clk);
    #1;
    start = 1'b0;
    abort = 1'b0;
    if (xf) begin
      bidx++;
      byte_in = gen_byte(bidx);
    end
    byte_vld = gap_mode ? 1'($urandom_range(0, 1)) : 1'b1;
  endtask

  task automatic launch(input logic [ADDR_W-1:0] b, input int c);
    base_addr = b;
    word_cnt  = CNT_W'(c);
    start     = 1'b1;
    bidx      = 0;
    byte_in   = gen_byte(0);
  endtask

  task automatic wait_done(input int budget, input string name);
    int d0;
    bit ok;
    d0 = n_done;
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (n_done != d0) begin
        ok = 1;
        break;
      end
    end
    chk(name, ok, 1'b1);
  endtask

  initial begin
    int d0;
    bit fin;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; byte_vld = 1'b0; byte_in = '0;
    base_addr = '0; word_cnt = '0;
    repeat (2) tick();
    start = 1'b1; base_addr = 13'h123; word_cnt = 14'd2;   // ignored under reset
    tick();
    chk("rst_busy", busy, 1'b0);
    chk("rst_we0", we0, 1'b0);
    rst_n = 1'b1;
    tick();
    chk("post_rst_busy", busy, 1'b0);
    chk("post_rst_done", done, 1'b0);

    // even count, continuous stream
    launch(13'h010, 2);
    wait_done(100, "even_done_seen");
    chk("even_nwr", wlog.size(), 1);
    if (wlog.size() >= 1) begin
      chk("even_a0", wlog[0].a0, 13'h010);
      chk("even_d0", wlog[0].d0, 32'h04030201);
      chk("even_we1", wlog[0].w1, 1'b1);
      chk("even_a1", wlog[0].a1, 13'h011);
      chk("even_d1", wlog[0].d1, 32'h08070605);
    end
    chk("even_lat", last_lat, 10);

    // odd count
    launch(13'h100, 3);
    wait_done(100, "odd_done_seen");
    chk("odd_nwr", wlog.size(), 2);
    if (wlog.size() >= 2) begin
      chk("odd_a0_2", wlog[1].a0, 13'h102);
      chk("odd_we1_2", wlog[1].w1, 1'b0);
      chk("odd_d0_2", wlog[1].d0, 32'h0C0B0A09);
    end
    chk("odd_lat", last_lat, 15);

    // address wrap
    launch(13'h1FFF, 2);
    wait_done(100, "wrap_done_seen");
    if (wlog.size() >= 1) begin
      chk("wrap_a0", wlog[0].a0, 13'h1FFF);
      chk("wrap_a1", wlog[0].a1, 13'h0000);
    end
    chk("wrap_nwr", wlog.size(), 1);

    // zero count: straight to done, no writes
    launch(13'h055, 0);
    wait_done(20, "zero_done_seen");
    chk("zero_nwr", wlog.size(), 0);
    chk("zero_lat", last_lat, 1);

    // gaps on the stream: same packed data
    gap_mode = 1;
    launch(13'h010, 2);
    wait_done(300, "gap_done_seen");
    if (wlog.size() >= 1) begin
      chk("gap_d0", wlog[0].d0, 32'h04030201);
      chk("gap_d1", wlog[0].d1, 32'h08070605);
    end
    gap_mode = 0;

    // abort after 6 of 8 bytes, then a clean reload
    d0 = n_done;
    launch(13'h020, 2);
    for (int i = 0; i < 50; i++) begin
      tick();
      if (bidx == 6) break;
    end
    chk("abort_at_6", bidx, 6);
    abort = 1'b1;
    tick();
    chk("abort_busy", busy, 1'b0);
    chk("abort_nodone", n_done, d0);
    chk("abort_nwr", wlog.size(), 0);
    launch(13'h030, 2);
    wait_done(100, "reload_done_seen");
    if (wlog.size() >= 1) begin
      chk("reload_a0", wlog[0].a0, 13'h030);
      chk("reload_d0", wlog[0].d0, 32'h04030201);
      chk("reload_d1", wlog[0].d1, 32'h08070605);
    end

    // start while busy is ignored
    launch(13'h040, 4);
    repeat (3) tick();
    start = 1'b1; base_addr = 13'h555; word_cnt = 14'd1;
    wait_done(100, "busy_start_done_seen");
    chk("busy_start_nwr", wlog.size(), 2);
    if (wlog.size() >= 2) begin
      chk("busy_start_a0_1", wlog[0].a0, 13'h040);
      chk("busy_start_a0_2", wlog[1].a0, 13'h042);
      chk("busy_start_d1_2", wlog[1].d1, 32'h100F0E0D);
    end
    chk("busy_start_lat", last_lat, 19);

    // reset in the middle of a load
    d0 = n_done;
    launch(13'h060, 3);
    repeat (10) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_nodone", n_done, d0);

    // randomized loads with gaps, random aborts and stray starts
    rand_bytes = 1;
    for (int k = 0; k < 25; k++) begin
      gap_mode = 1'($urandom_range(0, 1));
      launch(ADDR_W'($urandom), $urandom_range(0, 9));
      fin = 0;
      for (int i = 0; i < 400; i++) begin
        tick();
        if (!busy) begin
          fin = 1;
          break;
        end
        if ($urandom_range(0, 199) == 0) abort = 1'b1;
        if ($urandom_range(0, 29) == 0) begin
          start = 1'b1;
          base_addr = ADDR_W'($urandom);
          word_cnt = CNT_W'($urandom_range(1, 5));
        end
      end
      chk("rnd_finished", fin, 1'b1);
      tick();
    end

    repeat (3) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
